// File: rtl/lm_sm_sequencer_pkg.sv
// Shared constants and types for the LM/SM micro-op sequencer.
// Opcode values, state encoding and micro-IR field positions.
package lm_sm_sequencer_pkg;

  localparam int NREG = 8;
  localparam int IDXW = $clog2(NREG);

  localparam logic [3:0] LM_OP = 4'b0110;
  localparam logic [3:0] SM_OP = 4'b0111;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RA_HI   = 11;
  localparam int RA_LO   = 9;
  localparam int MASK_HI = NREG - 1;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  function automatic logic is_lsm_op(
    input logic [3:0] op
  );
    return (op == LM_OP) || (op == SM_OP);
  endfunction

endpackage

// File: rtl/lm_sm_sequencer_enc.sv
// Lowest-set-bit priority encoder for the register mask.
// Gives the index, the one-hot bit to clear and an all-zero flag.
module lowest_set_bit_enc
  import lm_sm_sequencer_pkg::*;
(
  input  logic [NREG-1:0] vec_i,
  output logic [IDXW-1:0] idx_o,
  output logic [NREG-1:0] clr_o,
  output logic            zero_o
);

  always_comb begin
    idx_o = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDXW'(i);
    end
  end

  // two's-complement trick isolates the lowest set bit
  assign clr_o  = vec_i & (~vec_i + NREG'(1));
  assign zero_o = ~|vec_i;

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM into one single-register micro-op per mask bit.
// Outputs are combinational so the first micro-op has zero latency.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_ir,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  output logic        ir_load_mux,
  output logic [15:0] new_ir,
  output logic        first_multiple,
  output logic        pc_write,
  output logic        busy
);

  state_e            state_q, state_d;
  logic [NREG-1:0]   mask_q, mask_d;
  logic [15:0]       ir_q, ir_d;

  logic              idle;
  logic [NREG-1:0]   rem;
  logic [15:0]       cur;
  logic [IDXW-1:0]   idx;
  logic [NREG-1:0]   clr;
  logic              rem_zero;
  logic [NREG-1:0]   rest;
  logic              last;
  logic              is_multi;
  logic              active;
  logic              unused_cur;

  assign idle = (state_q == IDLE);
  assign rem  = idle ? in_ir[MASK_HI:0] : mask_q;
  assign cur  = idle ? in_ir : ir_q;

  lowest_set_bit_enc u_enc (
    .vec_i  (rem),
    .idx_o  (idx),
    .clr_o  (clr),
    .zero_o (rem_zero)
  );

  assign rest = rem & ~clr;
  assign last = ~|rest;

  assign is_multi = in_valid
                 && is_lsm_op(in_ir[OP_HI:OP_LO])
                 && |in_ir[MASK_HI:0];

  // reset gating keeps outputs at their idle values while held in reset
  assign active = reset && !flush
               && (!idle || is_multi);

  assign unused_cur = ^{cur[RA_LO-1:0], rem_zero};

  always_comb begin
    ir_load_mux    = 1'b0;
    new_ir         = '0;
    first_multiple = 1'b0;
    pc_write       = !stall;
    busy           = !idle;
    if (!reset) begin
      pc_write = 1'b1;
    end else if (active) begin
      ir_load_mux    = 1'b1;
      new_ir         = {cur[OP_HI:OP_LO], idx,
                        cur[RA_HI:RA_LO], 6'b0};
      first_multiple = idle;
      pc_write       = last && !stall;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ir_d    = ir_q;
    if (flush) begin
      state_d = IDLE;
      mask_d  = '0;
    end else if (stall) begin
      state_d = state_q;
    end else if (idle) begin
      if (is_multi && !last) begin
        state_d = EMIT;
        mask_d  = rest;
        ir_d    = in_ir;
      end
    end else if (last) begin
      state_d = IDLE;
      mask_d  = '0;
    end else begin
      mask_d = rest;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: queue-based reference model checked
// every cycle, directed literal checks, then random stimulus.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_ir = '0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ir_load_mux;
  logic [15:0] new_ir;
  logic        first_multiple;
  logic        pc_write;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         q[$];
  logic [3:0] q_op;
  logic [2:0] q_ra;

  lm_sm_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .in_ir          (in_ir),
    .in_valid       (in_valid),
    .stall          (stall),
    .flush          (flush),
    .ir_load_mux    (ir_load_mux),
    .new_ir         (new_ir),
    .first_multiple (first_multiple),
    .pc_write       (pc_write),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Model: pending registers live in a queue of indices.
  always @(negedge clk) begin : model
    int         cand[$];
    logic [3:0] op;
    logic [2:0] ra;
    bit         emit, multi, act;
    logic       e_mux, e_fm, e_pw, e_bz;
    logic [15:0] e_ir;
    cyc++;
    cand.delete();
    op = '0;
    ra = '0;
    if (!reset) begin
      q.delete();
      e_mux = 0; e_ir = '0; e_fm = 0; e_pw = 1; e_bz = 0;
    end else begin
      emit  = (q.size() > 0);
      multi = in_valid
           && (in_ir[15:12] == 4'b0110 || in_ir[15:12] == 4'b0111)
           && (in_ir[7:0] != 8'h00);
      if (emit) begin
        cand = q; op = q_op; ra = q_ra;
      end else begin
        for (int i = 0; i < 8; i++)
          if (in_ir[i]) cand.push_back(i);
        op = in_ir[15:12];
        ra = in_ir[11:9];
      end
      act  = !flush && (emit || multi);
      e_bz = emit;
      if (act) begin
        e_mux = 1;
        e_ir  = {op, 3'(cand[0]), ra, 6'b0};
        e_fm  = !emit;
        e_pw  = (cand.size() == 1) && !stall;
      end else begin
        e_mux = 0; e_ir = '0; e_fm = 0; e_pw = !stall;
      end
      if (flush) begin
        q.delete();
      end else if (!stall && act) begin
        void'(cand.pop_front());
        q = cand; q_op = op; q_ra = ra;
      end
    end
    n_tests++;
    if ({ir_load_mux, new_ir, first_multiple, pc_write, busy}
        !== {e_mux, e_ir, e_fm, e_pw, e_bz}) begin
      n_fail++;
      $display("FAIL model cyc%0d got mux=%b ir=%h fm=%b pw=%b bz=%b want mux=%b ir=%h fm=%b pw=%b bz=%b",
               cyc, ir_load_mux, new_ir, first_multiple, pc_write, busy,
               e_mux, e_ir, e_fm, e_pw, e_bz);
    end
  end

  task automatic step(input logic [15:0] ir, input logic v,
                      input logic s, input logic f, input logic r);
    @(posedge clk);
    #1;
    in_ir = ir; in_valid = v; stall = s; flush = f; reset = r;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic m,
                     input logic [15:0] ir, input logic fm,
                     input logic pw, input logic bz);
    n_tests++;
    if ({ir_load_mux, new_ir, first_multiple, pc_write, busy}
        !== {m, ir, fm, pw, bz}) begin
      n_fail++;
      $display("FAIL lit %s got mux=%b ir=%h fm=%b pw=%b bz=%b want mux=%b ir=%h fm=%b pw=%b bz=%b",
               name, ir_load_mux, new_ir, first_multiple, pc_write, busy,
               m, ir, fm, pw, bz);
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] mk;
    logic [15:0] ir;
    step(16'h64A5, 1, 0, 0, 0);
    chk("reset", 0, 16'h0000, 0, 1, 0);
    step(16'h0000, 0, 0, 0, 1);
    chk("idle", 0, 16'h0000, 0, 1, 0);

    step(16'h64A5, 1, 0, 0, 1); chk("lm0", 1, 16'h6080, 1, 0, 0);
    step(16'h64A5, 1, 0, 0, 1); chk("lm1", 1, 16'h6480, 0, 0, 1);
    step(16'h64A5, 1, 0, 0, 1); chk("lm2", 1, 16'h6A80, 0, 0, 1);
    step(16'h64A5, 1, 0, 0, 1); chk("lm3", 1, 16'h6E80, 0, 1, 1);
    step(16'h0000, 1, 0, 0, 1); chk("lm_end", 0, 16'h0000, 0, 1, 0);

    step(16'h7280, 1, 0, 0, 1); chk("sm_r7", 1, 16'h7E40, 1, 1, 0);
    step(16'h0000, 1, 0, 0, 1); chk("sm_end", 0, 16'h0000, 0, 1, 0);

    step(16'h64A5, 1, 0, 0, 1); chk("st0", 1, 16'h6080, 1, 0, 0);
    step(16'h64A5, 1, 1, 0, 1); chk("st1a", 1, 16'h6480, 0, 0, 1);
    step(16'h64A5, 1, 1, 0, 1); chk("st1b", 1, 16'h6480, 0, 0, 1);
    step(16'h64A5, 1, 0, 0, 1); chk("st1c", 1, 16'h6480, 0, 0, 1);
    step(16'h64A5, 1, 0, 0, 1); chk("st2", 1, 16'h6A80, 0, 0, 1);
    step(16'h64A5, 1, 0, 0, 1); chk("st3", 1, 16'h6E80, 0, 1, 1);
    step(16'h0000, 1, 0, 0, 1); chk("st_end", 0, 16'h0000, 0, 1, 0);

    step(16'h64A5, 1, 0, 0, 1); chk("fl0", 1, 16'h6080, 1, 0, 0);
    step(16'h64A5, 1, 0, 0, 1); chk("fl1", 1, 16'h6480, 0, 0, 1);
    step(16'h64A5, 1, 0, 1, 1); chk("flush", 0, 16'h0000, 0, 1, 1);
    step(16'h0000, 1, 0, 0, 1); chk("fl_end", 0, 16'h0000, 0, 1, 0);

    step(16'h6400, 1, 0, 0, 1); chk("mask0", 0, 16'h0000, 0, 1, 0);
    step(16'h0000, 1, 0, 0, 1); chk("add", 0, 16'h0000, 0, 1, 0);

    step(16'h64A5, 1, 0, 0, 1); chk("rs0", 1, 16'h6080, 1, 0, 0);
    step(16'h64A5, 1, 0, 0, 0); chk("rs_mid", 0, 16'h0000, 0, 1, 0);
    step(16'h0000, 1, 0, 0, 1); chk("rs_rel", 0, 16'h0000, 0, 1, 0);
    step(16'h0000, 0, 0, 0, 1); chk("rs_hold", 0, 16'h0000, 0, 1, 0);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 4'b0110;
        4, 5, 6, 7: op = 4'b0111;
        default:    op = 4'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 7))
        0:       mk = 8'h00;
        1:       mk = 8'h01 << $urandom_range(0, 7);
        default: mk = 8'($urandom_range(0, 255));
      endcase
      ir = {op, 4'($urandom_range(0, 15)), mk};
      step(ir,
           $urandom_range(0, 99) < 90,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 6,
           $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Expands multi-register load/store instructions (LM opcode 4'b0110, SM opcode 4'b0111) into one single-register micro-instruction per set bit of the register mask.
- Sits between the IF/ID pipeline register and decode. Supplies the IR-override mux select, the replacement IR and the first-of-multiple flag.
- Holds PC writes off until the final micro-op, replacing the multi-op portion of the hazard unit.

Parameters:
- LM_OP, 4'b0110, opcode of load-multiple
- SM_OP, 4'b0111, opcode of store-multiple
- NREG, 8, register-file size; mask width in IR[7:0]

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- in_ir  in  16  instruction currently held in IF/ID (pr1 IR)
- in_valid  in  1  IF/ID holds a valid (non-flushed) instruction
- stall  in  1  downstream hold; freeze sequencer state
- flush  in  1  branch/jump squash of IF/ID; abort any sequence
- ir_load_mux  out  1  1 = decode must use new_ir instead of in_ir
- new_ir  out  16  generated micro-instruction
- first_multiple  out  1  1 on the first micro-op of a sequence (base address from RA); 0 on later ones (address from memory-stage increment)
- pc_write  out  1  PC/IF-ID update enable
- busy  out  1  sequence in progress (state EMIT)

Behaviour:
- State register: IDLE / EMIT, plus mask_q[7:0] and ir_q[15:0].
- Reset (reset=0, async): state=IDLE, mask_q=0, ir_q=0. Outputs while in reset: ir_load_mux=0, new_ir=0, first_multiple=0, pc_write=1, busy=0.
- is_multi = in_valid && (in_ir[15:12]==LM_OP || in_ir[15:12]==SM_OP) && in_ir[7:0]!=0.
- Working mask: rem = (state==IDLE) ? in_ir[7:0] : mask_q. Working IR: cur = (state==IDLE) ? in_ir : ir_q.
- Bit selection: idx = index of the lowest set bit of rem (R0 first). last = (rem with bit idx cleared)==0.
- Outputs are combinational from state/registers/in_ir, so there is zero latency: the first micro-op appears in the same cycle the LM/SM sits in IF/ID.
- Active condition: active = !flush && (state==EMIT || (state==IDLE && is_multi)). When active:
  - ir_load_mux=1
  - new_ir = {cur[15:12], idx[2:0], cur[11:9], 6'b0}
  - first_multiple = (state==IDLE)
  - pc_write = last && !stall
- When not active: ir_load_mux=0, new_ir=0, first_multiple=0, pc_write=!stall.
- busy = (state==EMIT).
- Transitions on clk rising edge:
  - flush=1 (highest priority): state=IDLE, mask_q=0.
  - stall=1: hold state, mask_q and ir_q.
  - IDLE & is_multi & !last: state=EMIT, mask_q = rem with bit idx cleared, ir_q=in_ir.
  - IDLE & is_multi & last (single-bit mask): remain IDLE.
  - EMIT & !last: mask_q = rem with bit idx cleared.
  - EMIT & last: state=IDLE, mask_q=0.
- Mask 8'h00: not treated as multi; passes through unchanged (ir_load_mux=0, pc_write=1).
- One micro-op is emitted per non-stalled cycle. A sequence of k set bits takes exactly k cycles, with pc_write=0 for the first k-1 cycles.
- Mask bit 7 (R7): emitted like any other bit. R7/PC write-back handling belongs to the write-back stage.
- Reset asserted mid-sequence: immediate return to IDLE; no further micro-ops.

Decomposition:
- Shared package: opcode constants LM_OP/SM_OP, state enum {IDLE, EMIT}, micro-IR field positions.
- One sub-module: lowest_set_bit_enc (8-bit priority encoder; outputs idx[2:0], a one-hot clear mask and a zero flag).

Test Plan:
- LM 16'h64A5 (base R2, mask A5), in_valid=1, no stall → new_ir 6080, 6480, 6A80, 6E80 on 4 consecutive cycles; first_multiple 1,0,0,0; pc_write 0,0,0,1; busy 0,1,1,1; IDLE afterwards.
- SM 16'h7280 (single bit R7) → one cycle: new_ir=16'h7E40, first_multiple=1, pc_write=1, state stays IDLE.
- LM 16'h64A5 with stall=1 for 2 cycles during the second micro-op → new_ir holds 16'h6480 for 3 cycles with pc_write=0; the sequence then completes normally.
- flush=1 while EMIT, emitting 16'h6A80 → that cycle ir_load_mux=0; next cycle state=IDLE, busy=0, no 16'h6E80 emitted.
- LM with mask 0 (16'h6400) and ADD 16'h0000 → ir_load_mux=0, pc_write=1, busy=0.
- reset pulled low mid-sequence after 16'h6080 → asynchronous return to IDLE; after release, the reset output values hold until a new LM/SM arrives.
